// File: rtl/model_trainer_differentiation_controller.sv
// model_trainer_differentiation_controller: streams samples through shared sub/div units and emits (x[i]-x[i-1])/LENGTH per index.
// Optional MODEL_TRAINER_DIFFERENTIATION_UNIT_SKIP_EN bypasses the divider when the latched period is 1.
module model_trainer_differentiation_controller #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    ready,
  output logic                    error,
  input  logic [CONTROL_SIZE-1:0] size_in,
  input  logic [DATA_SIZE-1:0]    length_in,
  output logic                    data_enable,
  input  logic                    data_in_enable,
  input  logic [DATA_SIZE-1:0]    data_in,
  output logic                    sub_start,
  output logic [DATA_SIZE-1:0]    sub_a,
  output logic [DATA_SIZE-1:0]    sub_b,
  input  logic                    sub_ready,
  input  logic [DATA_SIZE-1:0]    sub_result,
  output logic                    div_start,
  output logic [DATA_SIZE-1:0]    div_a,
  output logic [DATA_SIZE-1:0]    div_b,
  input  logic                    div_ready,
  input  logic [DATA_SIZE-1:0]    div_result,
  output logic                    data_out_enable,
  output logic [DATA_SIZE-1:0]    data_out,
  output logic [CONTROL_SIZE-1:0] index_out
);
  typedef enum logic [2:0] {IDLE, INPUT, SUB, DIV, EMIT, DONE} state_t;
  state_t state, state_nx;
  logic first;
  logic [CONTROL_SIZE-1:0] size_r, idx;
  logic [DATA_SIZE-1:0] len_r, x_r, prev, diff_r;
  logic len_zero, unit_skip, bypass;
  assign len_zero = len_r == '0;
`ifdef MODEL_TRAINER_DIFFERENTIATION_UNIT_SKIP_EN
  assign unit_skip = len_r == DATA_SIZE'(1);
`else
  assign unit_skip = 1'b0;
`endif
  assign bypass = len_zero || unit_skip;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx        = state;
    ready           = state == DONE;
    data_enable     = state == INPUT;
    sub_start       = state == SUB && first;
    div_start       = state == DIV && first;
    data_out_enable = state == EMIT;
    sub_a           = x_r;
    sub_b           = prev;
    div_a           = diff_r;
    div_b           = len_r;
    case (state)
      IDLE:    if (start) state_nx = size_in == '0 ? DONE : INPUT;
      INPUT:   if (data_in_enable) state_nx = SUB;
      SUB:     if (sub_ready) state_nx = bypass ? EMIT : DIV;
      DIV:     if (div_ready) state_nx = EMIT;
      EMIT:    state_nx = idx == size_r - CONTROL_SIZE'(1) ? DONE : INPUT;
      default: state_nx = IDLE;
    endcase
  end
  // first marks the entry cycle of SUB/DIV so each unit sees a single start pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      first     <= 1'b0;
      size_r    <= '0;
      len_r     <= '0;
      idx       <= '0;
      x_r       <= '0;
      prev      <= '0;
      diff_r    <= '0;
      error     <= 1'b0;
      data_out  <= '0;
      index_out <= '0;
    end else begin
      first <= 1'b0;
      case (state)
        IDLE: if (start) begin
          size_r <= size_in;
          len_r  <= length_in;
          idx    <= '0;
          prev   <= '0;
          error  <= length_in == '0;
        end
        INPUT: if (data_in_enable) begin
          x_r   <= data_in;
          first <= 1'b1;
        end
        SUB: if (sub_ready) begin
          prev   <= x_r;
          diff_r <= sub_result;
          first  <= !bypass;
          if (bypass) begin
            data_out  <= len_zero ? '0 : sub_result;
            index_out <= idx;
          end
        end
        DIV: if (div_ready) begin
          data_out  <= div_result;
          index_out <= idx;
        end
        EMIT:    idx <= idx + CONTROL_SIZE'(1);
        default: ;
      endcase
    end
endmodule

// File: tb/tb_model_trainer_differentiation_controller.sv
// tb_model_trainer_differentiation_controller: directed jobs against random-latency sub/div models, scoreboard on DATA_OUT.
module tb_model_trainer_differentiation_controller;
  localparam int D = 64;
  localparam int C = 64;
  logic clk = 0, rst_n = 0, start = 0;
  logic [C-1:0] size_in = '0;
  logic [D-1:0] length_in = '0;
  logic ready, error, data_enable, sub_start, div_start, data_out_enable;
  logic data_in_enable = 0, sub_ready = 0, div_ready = 0;
  logic [D-1:0] data_in = '0, sub_result = '0, div_result = '0;
  logic [D-1:0] sub_a, sub_b, div_a, div_b, data_out;
  logic [C-1:0] index_out;
  model_trainer_differentiation_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .error(error),
    .size_in(size_in), .length_in(length_in), .data_enable(data_enable),
    .data_in_enable(data_in_enable), .data_in(data_in), .sub_start(sub_start),
    .sub_a(sub_a), .sub_b(sub_b), .sub_ready(sub_ready), .sub_result(sub_result),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_ready(div_ready),
    .div_result(div_result), .data_out_enable(data_out_enable), .data_out(data_out),
    .index_out(index_out));
  always #5 clk = ~clk;
  int compares = 0, fails = 0;
  int ready_cnt = 0, out_cnt = 0, sub_cnt = 0, div_cnt = 0, de_cnt = 0;
  int sub_wait = 0, div_wait = 0;
  logic [D-1:0] sub_hold, div_hold;
  logic [D-1:0] data_q[$], exp_d[$];
  logic [C-1:0] exp_i[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (data_out_enable) begin
      if (exp_d.size() == 0) begin
        compares++;
        fails++;
        $display("FAIL unexpected_out: got data %0d index %0d, expected no output", data_out, index_out);
      end else begin
        chk("data_out", data_out, exp_d.pop_front());
        chk("index_out", index_out, exp_i.pop_front());
      end
      out_cnt++;
    end
    if (ready) ready_cnt++;
    if (sub_start) sub_cnt++;
    if (div_start) div_cnt++;
    if (data_enable) de_cnt++;
  end
  always @(negedge clk)
    if (data_enable && !data_in_enable && data_q.size() > 0) begin
      data_in_enable = 1;
      data_in = data_q.pop_front();
    end else data_in_enable = 0;
  always @(negedge clk) begin
    sub_ready = 0;
    if (!rst_n) sub_wait = 0;
    else if (sub_wait > 0) begin
      sub_wait--;
      if (sub_wait == 0) begin sub_ready = 1; sub_result = sub_hold; end
    end else if (sub_start) begin
      sub_hold = sub_a - sub_b;
      sub_wait = $urandom_range(0, 3);
      if (sub_wait == 0) begin sub_ready = 1; sub_result = sub_hold; end
    end
  end
  always @(negedge clk) begin
    div_ready = 0;
    if (!rst_n) div_wait = 0;
    else if (div_wait > 0) begin
      div_wait--;
      if (div_wait == 0) begin div_ready = 1; div_result = div_hold; end
    end else if (div_start) begin
      div_hold = div_b == '0 ? '1 : div_a / div_b;
      div_wait = $urandom_range(0, 3);
      if (div_wait == 0) begin div_ready = 1; div_result = div_hold; end
    end
  end
  task automatic push(input logic [D-1:0] x, input logic [D-1:0] y, input logic [C-1:0] i);
    data_q.push_back(x);
    exp_d.push_back(y);
    exp_i.push_back(i);
  endtask
  task automatic run_job(input logic [C-1:0] sz, input logic [D-1:0] len, output int cyc);
    @(negedge clk);
    start = 1; size_in = sz; length_in = len;
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (!ready && cyc < 400) begin @(negedge clk); cyc++; end
    chk("ready_timeout", 64'(cyc < 400), 64'(1));
    repeat (3) @(negedge clk);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({ready, error, data_enable, sub_start, div_start, data_out_enable}), 64'(0));
    chk({tag, "_data"}, data_out | sub_a | sub_b | div_a | div_b, 64'(0));
    chk({tag, "_index"}, index_out, 64'(0));
  endtask
  int cyc, r0, o0, s0, d0, e0, k;
  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    // 1: basic job
    push(2, 1, 0); push(6, 2, 1); push(6, 0, 2); push(10, 2, 3);
    r0 = ready_cnt;
    run_job(4, 2, cyc);
    chk("t1_ready_cnt", 64'(ready_cnt - r0), 64'(1));
    chk("t1_error", 64'(error), 64'(0));
    chk("t1_left", 64'(exp_d.size()), 64'(0));
    // 2: empty job
    r0 = ready_cnt; s0 = sub_cnt; d0 = div_cnt; e0 = de_cnt;
    run_job(0, 5, cyc);
    chk("t2_latency", 64'(cyc), 64'(0));
    chk("t2_ready_cnt", 64'(ready_cnt - r0), 64'(1));
    chk("t2_data_enable", 64'(de_cnt - e0), 64'(0));
    chk("t2_sub_start", 64'(sub_cnt - s0), 64'(0));
    chk("t2_div_start", 64'(div_cnt - d0), 64'(0));
    // 3: zero period
    push(5, 0, 0); push(7, 0, 1); push(9, 0, 2);
    s0 = sub_cnt; d0 = div_cnt;
    run_job(3, 0, cyc);
    chk("t3_error", 64'(error), 64'(1));
    chk("t3_sub_start", 64'(sub_cnt - s0), 64'(3));
    chk("t3_div_start", 64'(div_cnt - d0), 64'(0));
    repeat (5) @(negedge clk);
    chk("t3_error_sticky", 64'(error), 64'(1));
    // 4: START mid-job ignored
    push(10, 2, 0); push(20, 2, 1); push(40, 4, 2); push(80, 8, 3);
    o0 = out_cnt;
    fork
      run_job(4, 5, cyc);
      begin
        repeat (6) @(negedge clk);
        start = 1; size_in = 9;
        @(negedge clk);
        start = 0;
      end
    join
    e0 = de_cnt;
    repeat (20) @(negedge clk);
    chk("t4_outputs", 64'(out_cnt - o0), 64'(4));
    chk("t4_no_restart", 64'(de_cnt - e0), 64'(0));
    chk("t4_error_cleared", 64'(error), 64'(0));
    // 5: reset during DIV of the second sample
    push(4, 2, 0);
    data_q.push_back(10); data_q.push_back(16);
    @(negedge clk);
    start = 1; size_in = 3; length_in = 2;
    @(negedge clk);
    start = 0;
    k = 0;
    while (!(div_start && sub_b == 10) && k < 400) begin @(negedge clk); k++; end
    chk("t5_reach_div", 64'(k < 400), 64'(1));
    #1 rst_n = 0;
    #1 chk_zero("t5_async");
    data_q.delete(); exp_d.delete(); exp_i.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    push(8, 2, 0);
    run_job(1, 4, cyc);
    chk("t5_left", 64'(exp_d.size()), 64'(0));
    // 6: period of one
    push(1, 1, 0); push(4, 3, 1); push(9, 5, 2);
    d0 = div_cnt;
    run_job(3, 1, cyc);
`ifdef MODEL_TRAINER_DIFFERENTIATION_UNIT_SKIP_EN
    chk("t6_div_start", 64'(div_cnt - d0), 64'(0));
`else
    chk("t6_div_start", 64'(div_cnt - d0), 64'(3));
`endif
    chk("t6_left", 64'(exp_d.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
